// File: rtl/ifu_fetch_queue.sv
// Fetch unit: owns the PC, reads even/odd instruction pairs from the ROM and queues them for decode.
// Optional IFU_BYPASS_EN presents the eve word combinationally when the queue is empty.
module ifu_fetch_queue #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       AWIDTH   = 30,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_vld,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic              rom_cs,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_dout_eve,
  input  logic [WIDTH-1:0]  rom_dout_odd,
  output logic              inst_vld,
  input  logic              inst_rdy,
  output logic [WIDTH-1:0]  inst,
  output logic [AWIDTH-1:0] inst_pc
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, pc_p1;
  logic [CW-1:0]     count_q, count_d, free, remaining;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_p1;
  logic [WIDTH-1:0]  mem_inst_q [QDEPTH];
  logic [AWIDTH-1:0] mem_pc_q   [QDEPTH];
  logic [WIDTH-1:0]  head_inst_q, head_inst_d;
  logic [AWIDTH-1:0] head_pc_q, head_pc_d;

  logic              fetch_ok, fetch_pair, fetch_one, bypass, bypass_taken, deq;
  logic [1:0]        n_wr;
  logic [WIDTH-1:0]  w0_inst, w1_inst;
  logic [AWIDTH-1:0] w0_pc, w1_pc;

  // State follows fetch_en; redirect never touches it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fetch_en) state_d = StRun;
      StRun:   if (!fetch_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Free space comes from the registered count; a same-cycle dequeue is not credited.
  assign free       = CW'(QDEPTH) - count_q;
  assign fetch_ok   = (state_q == StRun) && fetch_en && !redirect_vld;
  assign fetch_pair = fetch_ok && (free >= CW'(2));
  assign fetch_one  = fetch_ok && (free == CW'(1));
  assign rom_cs     = fetch_pair || fetch_one;
  assign rom_addr   = pc_q;
  assign pc_p1      = pc_q + AWIDTH'(1);
  assign wr_ptr_p1  = wr_ptr_q + PW'(1);

`ifdef IFU_BYPASS_EN
  // An empty queue always has room for a pair, so bypass only ever sees pair fetches.
  assign bypass = rom_cs && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign inst_vld     = bypass || (count_q != '0);
  assign inst         = bypass ? rom_dout_eve : head_inst_q;
  assign inst_pc      = bypass ? pc_q : head_pc_q;
  assign bypass_taken = bypass && inst_rdy;
  assign deq          = inst_vld && inst_rdy && !bypass;

  always_comb begin
    n_wr    = 2'd0;
    w0_inst = rom_dout_eve;
    w0_pc   = pc_q;
    w1_inst = rom_dout_odd;
    w1_pc   = pc_p1;
    pc_d    = pc_q;
    if (fetch_pair) begin
      pc_d = pc_q + AWIDTH'(2);
      if (bypass_taken) begin
        n_wr    = 2'd1;
        w0_inst = rom_dout_odd;
        w0_pc   = pc_p1;
      end else begin
        n_wr = 2'd2;
      end
    end else if (fetch_one) begin
      n_wr = 2'd1;
      pc_d = pc_p1;
    end
    if (redirect_vld) begin
      pc_d = redirect_addr;
    end
  end

  always_comb begin
    remaining = count_q - CW'(deq);
    if (redirect_vld) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(n_wr) - CW'(deq);
      rd_ptr_d = rd_ptr_q + PW'(deq);
      wr_ptr_d = wr_ptr_q + PW'(n_wr);
    end
  end

  // Next head: a surviving entry if one remains, else the first word written this cycle.
  always_comb begin
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    if (count_d != '0) begin
      if (remaining != '0) begin
        head_inst_d = mem_inst_q[rd_ptr_d];
        head_pc_d   = mem_pc_q[rd_ptr_d];
      end else begin
        head_inst_d = w0_inst;
        head_pc_d   = w0_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      head_inst_q <= '0;
      head_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      if (n_wr != 2'd0) begin
        mem_inst_q[wr_ptr_q] <= w0_inst;
        mem_pc_q[wr_ptr_q]   <= w0_pc;
      end
      if (n_wr == 2'd2) begin
        mem_inst_q[wr_ptr_p1] <= w1_inst;
        mem_pc_q[wr_ptr_p1]   <= w1_pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: a ROM model feeds the DUT, a negedge monitor checks decode
// handshakes against a scoreboard of expected PCs, and the stimulus thread checks fetch outputs.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_vld;
  logic [29:0] redirect_addr;
  logic        rom_cs;
  logic [29:0] rom_addr;
  logic [31:0] rom_dout_eve;
  logic [31:0] rom_dout_odd;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [29:0] inst_pc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [29:0] exp_q[$];

`ifdef IFU_BYPASS_EN
  localparam int HP = 10;
`else
  localparam int HP = 9;
`endif

  ifu_fetch_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .redirect_vld (redirect_vld),
    .redirect_addr(redirect_addr),
    .rom_cs       (rom_cs),
    .rom_addr     (rom_addr),
    .rom_dout_eve (rom_dout_eve),
    .rom_dout_odd (rom_dout_odd),
    .inst_vld     (inst_vld),
    .inst_rdy     (inst_rdy),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romf(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5EED_0F0F;
  endfunction

  assign rom_dout_eve = romf(rom_addr);
  assign rom_dout_odd = romf(rom_addr + 30'd1);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic push_range(input logic [29:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 30'(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completed decode handshake must match the next expected PC.
  always @(negedge clk) begin
    logic [29:0] p;
    if (rst_n && inst_vld && inst_rdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_inst: got pc %h inst %h, required none", inst_pc, inst);
      end else begin
        p = exp_q.pop_front();
        if (inst_pc !== p || inst !== romf(p)) begin
          n_err++;
          $display("FAIL decode_inst: got pc %h inst %h required pc %h inst %h",
                   inst_pc, inst, p, romf(p));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_vld = 1'b0; redirect_addr = '0; inst_rdy = 1'b0;
    #3;
    chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("rst_rom_addr", {2'b0, rom_addr}, 32'd0);
    chk("rst_inst_vld", {31'd0, inst_vld}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", {2'b0, inst_pc}, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // Streaming with decode always ready.
    step();
    push_range(30'd0, HP);
    fetch_en = 1'b1; inst_rdy = 1'b1;
    #1 chk("idle_no_cs", {31'd0, rom_cs}, 32'd0);
    step(); #1;
    chk("first_cs", {31'd0, rom_cs}, 32'd1);
    chk("first_addr", {2'b0, rom_addr}, 32'd0);
    step(); #1 chk("addr_2", {2'b0, rom_addr}, 32'd2);
    step(); #1 chk("addr_4", {2'b0, rom_addr}, 32'd4);
    repeat (5) step();
    fetch_en = 1'b0;
    #1 chk("fen_drop_cs", {31'd0, rom_cs}, 32'd0);
    repeat (3) step(); #1;
    chk("drained_vld", {31'd0, inst_vld}, 32'd0);
    chk("held_pc", {2'b0, rom_addr}, 32'(HP));
    chk("drain1_sb", exp_q.size(), 32'd0);

    // Resume with decode stalled: queue fills, then one credit gives a single-word fetch.
    step();
    push_range(30'(HP), 2);
    fetch_en = 1'b1; inst_rdy = 1'b0;
    #1 chk("idle_again_cs", {31'd0, rom_cs}, 32'd0);
    step(); #1;
    chk("resume_cs", {31'd0, rom_cs}, 32'd1);
    chk("resume_addr", {2'b0, rom_addr}, 32'(HP));
    step();
    step(); #1;
    chk("full_cs", {31'd0, rom_cs}, 32'd0);
    chk("full_pc_hold", {2'b0, rom_addr}, 32'(HP + 4));
    inst_rdy = 1'b1;
    #1 chk("full_no_credit", {31'd0, rom_cs}, 32'd0);
    step();
    inst_rdy = 1'b0;
    #1;
    chk("single_cs", {31'd0, rom_cs}, 32'd1);
    chk("single_addr", {2'b0, rom_addr}, 32'(HP + 4));
    step(); #1;
    chk("after_single_pc", {2'b0, rom_addr}, 32'(HP + 5));
    chk("after_single_cs", {31'd0, rom_cs}, 32'd0);
    fetch_en = 1'b0; inst_rdy = 1'b1;

    // Redirect with three entries queued.
    step();
    inst_rdy = 1'b0; fetch_en = 1'b1; redirect_vld = 1'b1; redirect_addr = 30'h100;
    push_range(30'h100, 4);
    #1;
    chk("pre_redir_vld", {31'd0, inst_vld}, 32'd1);
    chk("redir_cs", {31'd0, rom_cs}, 32'd0);
    step();
    redirect_vld = 1'b0;
    #1;
    chk("redir_addr", {2'b0, rom_addr}, 32'h100);
    chk("redir_fetch_cs", {31'd0, rom_cs}, 32'd1);
`ifdef IFU_BYPASS_EN
    chk("redir_n1_vld", {31'd0, inst_vld}, 32'd1);
    chk("redir_n1_pc", {2'b0, inst_pc}, 32'h100);
`else
    chk("redir_n1_vld", {31'd0, inst_vld}, 32'd0);
`endif
    step(); #1;
    chk("redir_n2_vld", {31'd0, inst_vld}, 32'd1);
    chk("redir_n2_pc", {2'b0, inst_pc}, 32'h100);
    step();
    fetch_en = 1'b0; inst_rdy = 1'b1;
    repeat (4) step(); #1;
    chk("drain2_vld", {31'd0, inst_vld}, 32'd0);
    chk("drain2_sb", exp_q.size(), 32'd0);

    // PC wrap at the top of the address space.
    fetch_en = 1'b1; inst_rdy = 1'b0; redirect_vld = 1'b1; redirect_addr = 30'h3FFF_FFFF;
    push_range(30'h3FFF_FFFF, 4);
    step();
    redirect_vld = 1'b0;
    #1;
    chk("wrap_addr", {2'b0, rom_addr}, 32'h3FFF_FFFF);
    chk("wrap_cs", {31'd0, rom_cs}, 32'd1);
    step(); #1;
    chk("wrap_next_addr", {2'b0, rom_addr}, 32'd1);
    step();
    fetch_en = 1'b0; inst_rdy = 1'b1;
    repeat (4) step(); #1;
    chk("drain3_vld", {31'd0, inst_vld}, 32'd0);
    chk("drain3_sb", exp_q.size(), 32'd0);

    // Asynchronous reset while fetching with entries queued.
    fetch_en = 1'b1; inst_rdy = 1'b0; redirect_vld = 1'b1; redirect_addr = 30'h40;
    step();
    redirect_vld = 1'b0;
    step(); #1;
    chk("prerst_cs", {31'd0, rom_cs}, 32'd1);
    chk("prerst_vld", {31'd0, inst_vld}, 32'd1);
    chk("prerst_addr", {2'b0, rom_addr}, 32'h42);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", {31'd0, rom_cs}, 32'd0);
    chk("arst_vld", {31'd0, inst_vld}, 32'd0);
    chk("arst_addr", {2'b0, rom_addr}, 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", {2'b0, inst_pc}, 32'd0);
    step(); step();
    chk("final_sb", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
